alu_cmd_sequencer: RTL and testbench
====================================

// Module: alu_cmd_sequencer
// PURPOSE
//   Issuing side of the ALU command interface. Holds a small program of 12-bit commands and
//   presents them one at a time on cmd_out, with a one-cycle run pulse per command. After each
//   issue it waits a fixed ALU latency, then captures the result word y and the O/C/Z/N flags
//   into a result buffer. Sits between the host/testbench and the controller + ALU datapath.
// PARAMETERS
//   CMD_W     12   command width, matches the controller command input
//   DATA_W    32   ALU result width
//   DEPTH     8    program/result slots; power of two, >= 2
//   ALU_LAT   2    cycles from the run pulse to a valid y/flags sample; 1..15
//   HALT_CMD  12'hFFF  sentinel command: ends the program and is not issued
// PORTS
//   clk        in   1                clock, rising edge
//   rst        in   1                reset, asynchronous, active-high
//   ld_en      in   1                write ld_cmd into program slot ld_addr (ignored while busy)
//   ld_addr    in   $clog2(DEPTH)    program slot to write
//   ld_cmd     in   CMD_W            command to store
//   start      in   1                begin executing from slot 0 (ignored while busy)
//   cmd_out    out  CMD_W            command presented to the controller
//   run        out  1                one-cycle issue strobe (controller syscall input)
//   alu_y      in   DATA_W           ALU result
//   alu_flags  in   4                {O,C,Z,N} from the ALU
//   busy       out  1                high from start accept until the done pulse
//   done       out  1                one-cycle pulse when the program ends
//   n_exec     out  $clog2(DEPTH)+1  number of commands executed in the last run
//   rd_addr    in   $clog2(DEPTH)    result slot to read
//   rd_y       out  DATA_W           captured result, combinational read of slot rd_addr
//   rd_flags   out  4                captured flags, combinational read of slot rd_addr
// BEHAVIOUR
//   Reset: FSM=IDLE; cmd_out=0, run=0, busy=0, done=0, n_exec=0, pc=0, wait counter=0.
//     The program and result arrays are not reset. Reset asserted mid-run aborts the run with
//     no done pulse.
//   FSM states: IDLE -> FETCH -> ISSUE -> WAIT -> CAPTURE -> (FETCH | FINISH) -> IDLE.
//   IDLE: on start, set pc=0 and n_exec=0, assert busy, and go to FETCH.
//     If start and ld_en arrive in the same cycle, the load completes first and start is accepted.
//   FETCH: read prog[pc]. If it equals HALT_CMD, go to FINISH; otherwise register it onto cmd_out
//     and go to ISSUE.
//   ISSUE: run=1 for exactly this cycle, with cmd_out stable. Load the counter with ALU_LAT-1 and
//     go to WAIT. cmd_out holds its value until the next ISSUE.
//   WAIT: decrement the counter. When it reaches 0, go to CAPTURE. Between the run pulse and the
//     capture edge there are exactly ALU_LAT clock edges.
//   CAPTURE: res_y[pc]<=alu_y, res_flags[pc]<=alu_flags, n_exec<=n_exec+1.
//     If pc==DEPTH-1, go to FINISH (pc does not wrap). Otherwise pc<=pc+1 and go to FETCH.
//   FINISH: done=1 for one cycle, busy<=0, then go to IDLE.
//   Per-command cost is ALU_LAT+3 cycles. A program with no HALT runs all DEPTH slots, and
//     n_exec=DEPTH.
//   A HALT at slot 0 gives done two cycles after start with n_exec=0 and no run pulse.
//   While busy, ld_en and start are dropped silently. Result reads are legal at any time.
//     During a run, slots at or beyond pc hold stale data.
// STRUCTURE
//   Shared package alu_if_pkg: CMD_W, DATA_W, the flag index constants (FLAG_O=3, FLAG_C=2,
//     FLAG_Z=1, FLAG_N=0), HALT_CMD, and the seq_state_t enum.
//   One sub-module: seq_result_ram, a DEPTH x (DATA_W+4) register file with one synchronous
//     write port and one asynchronous read port. The program store is a plain array in this module.
// TESTING
//   1. Load slots 0..2 with 12'h101, 12'h202, HALT_CMD, then start. Expect 2 run pulses, with
//      cmd_out=101 then 202, spaced ALU_LAT+3 cycles apart. Expect done 1 cycle after the 2nd
//      capture, n_exec=2.
//   2. Use an ALU model that returns y=32'hDEAD_0000+cmd with Z=0. After done, expect
//      rd_addr=1 -> rd_y=32'hDEAD_0202, rd_flags per the model.
//   3. Put HALT_CMD at slot 0 and start. Expect no run pulse, done on cycle 2, n_exec=0,
//      busy high for 2 cycles.
//   4. Load all 8 slots with non-HALT commands. Expect 8 run pulses, pc stops at 7 with no
//      wrap, and n_exec=8.
//   5. Assert rst during WAIT of the 2nd command. Expect run=0, busy=0, cmd_out=0, and no done.
//      A subsequent start re-runs from slot 0.
//   6. Pulse start and an ld_en to slot 0 while busy. Expect both ignored, the program unchanged,
//      and the current run completing normally.

Source files
------------

// File: rtl/alu_if_pkg.sv
// Shared definitions for the ALU command interface: widths, flag bit
// positions, the halt sentinel and the sequencer state encoding.
package alu_if_pkg;

    localparam int CMD_W  = 12;
    localparam int DATA_W = 32;

    // Bit positions inside the 4-bit {O,C,Z,N} flag word
    localparam int FLAG_O = 3;
    localparam int FLAG_C = 2;
    localparam int FLAG_Z = 1;
    localparam int FLAG_N = 0;

    localparam logic [CMD_W-1:0] HALT_CMD = 12'hFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_FINISH
    } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer_if.sv
// Command/result link between the sequencer (master) and the
// controller + ALU datapath (slave).
interface alu_cmd_if;
    import alu_if_pkg::*;

    logic [CMD_W-1:0]  cmd_out;
    logic              run;
    logic [DATA_W-1:0] alu_y;
    logic [3:0]        alu_flags;

    modport master (output cmd_out, output run, input alu_y, input alu_flags);
    modport slave  (input cmd_out, input run, output alu_y, output alu_flags);

endinterface

// File: rtl/seq_result_ram.sv
// Result buffer: DEPTH x W register file, one synchronous write port and
// one asynchronous read port. Contents are deliberately not reset.
module seq_result_ram #(
    parameter int DEPTH = 8,
    parameter int W     = 36
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [W-1:0]             wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [W-1:0]             rdata_o
);

    logic [W-1:0] mem_q [DEPTH];

    // Store a captured result word
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/alu_cmd_sequencer.sv
// Issuing side of the ALU command interface: steps through a small program
// of commands, pulses run once per command, waits the ALU latency and
// captures y/flags into the result buffer.
module alu_cmd_sequencer #(
    parameter int                          CMD_W    = alu_if_pkg::CMD_W,
    parameter int                          DATA_W   = alu_if_pkg::DATA_W,
    parameter int                          DEPTH    = 8,
    parameter int                          ALU_LAT  = 2,
    parameter logic [alu_if_pkg::CMD_W-1:0] HALT_CMD = alu_if_pkg::HALT_CMD
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ld_en,
    input  logic [$clog2(DEPTH)-1:0]   ld_addr,
    input  logic [CMD_W-1:0]           ld_cmd,
    input  logic                       start,
    alu_cmd_if.master                  alu,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     n_exec,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [DATA_W-1:0]          rd_y,
    output logic [3:0]                 rd_flags
);
    import alu_if_pkg::*;

    localparam int         AW     = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

    seq_state_t         state_q;
    logic [CMD_W-1:0]   cmd_q;
    logic               run_q;
    logic               busy_q;
    logic               done_q;
    logic [AW:0]        n_exec_q;
    logic [AW-1:0]      pc_q;
    logic [3:0]         cnt_q;

    logic [CMD_W-1:0]   prog_q [DEPTH];
    logic [CMD_W-1:0]   fetch_cmd_d;
    logic               cap_we_d;
    logic [DATA_W+3:0]  rd_word;

    // Program store: host writes are only honoured while the sequencer is idle
    always_ff @(posedge clk) begin
        if (ld_en && !busy_q) begin
            prog_q[ld_addr] <= ld_cmd;
        end
    end

    assign fetch_cmd_d = prog_q[pc_q];
    assign cap_we_d    = (state_q == S_CAPTURE);

    // Sequencer FSM with registered run/done/busy/cmd outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cmd_q    <= '0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            n_exec_q <= '0;
            pc_q     <= '0;
            cnt_q    <= '0;
        end else begin
            run_q  <= 1'b0;
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        pc_q     <= '0;
                        n_exec_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    if (fetch_cmd_d == HALT_CMD) begin
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        cmd_q   <= fetch_cmd_d;
                        run_q   <= 1'b1;
                        state_q <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    cnt_q   <= LAT_M1;
                    state_q <= S_WAIT;
                end
                S_WAIT: begin
                    // Counter starts at ALU_LAT-1, so WAIT lasts ALU_LAT cycles
                    if (cnt_q == 4'd0) begin
                        state_q <= S_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_CAPTURE: begin
                    n_exec_q <= n_exec_q + (AW+1)'(1);
                    // Last slot ends the program; pc never wraps back to 0
                    if (pc_q == AW'(DEPTH - 1)) begin
                        done_q  <= 1'b1;
                        state_q <= S_FINISH;
                    end else begin
                        pc_q    <= pc_q + AW'(1);
                        state_q <= S_FETCH;
                    end
                end
                S_FINISH: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    seq_result_ram #(
        .DEPTH (DEPTH),
        .W     (DATA_W + 4)
    ) u_res (
        .clk     (clk),
        .we_i    (cap_we_d),
        .waddr_i (pc_q),
        .wdata_i ({alu.alu_flags, alu.alu_y}),
        .raddr_i (rd_addr),
        .rdata_o (rd_word)
    );

    assign alu.cmd_out = cmd_q;
    assign alu.run     = run_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign n_exec      = n_exec_q;
    assign rd_y        = rd_word[DATA_W-1:0];
    assign rd_flags    = rd_word[DATA_W+3:DATA_W];

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a command scoreboard and a
// simple ALU model (y = DEAD_0000 + cmd, Z always 0).
module tb_alu_cmd_sequencer;
    import alu_if_pkg::*;

    localparam int DEPTH   = 8;
    localparam int ALU_LAT = 2;
    localparam int AW      = 3;
    localparam int PER     = ALU_LAT + 3;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ld_en = 1'b0;
    logic [AW-1:0]     ld_addr = '0;
    logic [CMD_W-1:0]  ld_cmd = '0;
    logic              start = 1'b0;
    logic              busy, done;
    logic [AW:0]       n_exec;
    logic [AW-1:0]     rd_addr = '0;
    logic [DATA_W-1:0] rd_y;
    logic [3:0]        rd_flags;

    int n_assert = 0;
    int n_fail   = 0;

    logic [CMD_W-1:0] exp_q[$];
    logic [CMD_W-1:0] prog_m [DEPTH];

    always #5 clk = ~clk;

    alu_cmd_if alu();

    alu_cmd_sequencer #(.DEPTH(DEPTH), .ALU_LAT(ALU_LAT)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_cmd   (ld_cmd),
        .start    (start),
        .alu      (alu),
        .busy     (busy),
        .done     (done),
        .n_exec   (n_exec),
        .rd_addr  (rd_addr),
        .rd_y     (rd_y),
        .rd_flags (rd_flags)
    );

    // ALU model: result follows the presented command
    function automatic logic [DATA_W-1:0] model_y(logic [CMD_W-1:0] c);
        return 32'hDEAD_0000 + {20'h0, c};
    endfunction

    function automatic logic [3:0] model_f(logic [CMD_W-1:0] c);
        logic [3:0] f;
        f         = 4'h0;
        f[FLAG_O] = c[11];
        f[FLAG_C] = c[1];
        f[FLAG_Z] = 1'b0;
        f[FLAG_N] = c[0];
        return f;
    endfunction

    assign alu.alu_y     = model_y(alu.cmd_out);
    assign alu.alu_flags = model_f(alu.cmd_out);

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(int a, logic [CMD_W-1:0] c);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = AW'(a);
        ld_cmd  = c;
        @(negedge clk);
        ld_en   = 1'b0;
        prog_m[a] = c;
    endtask

    task automatic chk_res(string tag, int slot);
        rd_addr = AW'(slot);
        #1;
        chk({tag, " rd_y"}, rd_y, model_y(prog_m[slot]));
        chk({tag, " rd_flags"}, rd_flags, model_f(prog_m[slot]));
    endtask

    // Start the program, compare every issued command against the
    // scoreboard, and check done timing, run spacing, busy and n_exec.
    task automatic run_prog(string tag, int poke_cyc);
        int cyc, last_run, runs, done_cyc, n_cmd, exp_done;
        bit busy_ok, spacing_ok;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) begin
            if (prog_m[i] == HALT_CMD) break;
            exp_q.push_back(prog_m[i]);
        end
        n_cmd      = exp_q.size();
        exp_done   = PER * n_cmd + ((n_cmd == DEPTH) ? 1 : 2);
        busy_ok    = 1'b1;
        spacing_ok = 1'b1;
        runs       = 0;
        last_run   = 0;
        done_cyc   = -1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (cyc < 200) begin
            if (poke_cyc > 0 && cyc == poke_cyc) begin
                start   = 1'b1;
                ld_en   = 1'b1;
                ld_addr = '0;
                ld_cmd  = 12'h777;
            end else if (poke_cyc > 0 && cyc == poke_cyc + 1) begin
                start = 1'b0;
                ld_en = 1'b0;
            end
            if (busy !== 1'b1) busy_ok = 1'b0;
            if (alu.run === 1'b1) begin
                if (exp_q.size() == 0) chk({tag, " extra run"}, alu.run, 1'b0);
                else chk({tag, " cmd_out"}, alu.cmd_out, exp_q.pop_front());
                if (runs > 0 && cyc - last_run != PER) spacing_ok = 1'b0;
                last_run = cyc;
                runs++;
            end
            if (done === 1'b1) begin
                done_cyc = cyc;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ld_en = 1'b0;
        chk({tag, " done cycle"}, done_cyc, exp_done);
        chk({tag, " run count"}, runs, n_cmd);
        chk({tag, " run spacing"}, spacing_ok, 1'b1);
        chk({tag, " busy held"}, busy_ok, 1'b1);
        chk({tag, " n_exec"}, n_exec, n_cmd);
        @(negedge clk);
        chk({tag, " done pulse"}, done, 1'b0);
        chk({tag, " busy after"}, busy, 1'b0);
    endtask

    initial begin
        int runs_seen;
        bit seen_done, seen_run;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst cmd_out", alu.cmd_out, 12'h000);
        chk("rst run", alu.run, 1'b0);
        chk("rst busy", busy, 1'b0);
        chk("rst done", done, 1'b0);
        chk("rst n_exec", n_exec, 4'd0);
        rst = 1'b0;

        // Two commands then HALT
        load(0, 12'h101);
        load(1, 12'h202);
        load(2, HALT_CMD);
        run_prog("t1", 0);

        // Captured results
        chk_res("t2 slot1", 1);
        chk_res("t2 slot0", 0);
        rd_addr = 3'd1;
        #1;
        chk("t2 y literal", rd_y, 32'hDEAD_0202);
        chk("t2 Z flag", rd_flags[FLAG_Z], 1'b0);

        // HALT at slot 0
        load(0, HALT_CMD);
        run_prog("t3", 0);

        // Full program, no HALT
        for (int i = 0; i < DEPTH; i++) load(i, 12'h010 + 12'(i * 17));
        run_prog("t4", 0);
        for (int i = 0; i < DEPTH; i++) chk_res("t4 slot", i);

        // Reset during WAIT of the 2nd command
        load(0, 12'h101);
        load(1, 12'h202);
        load(2, HALT_CMD);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        runs_seen = 0;
        for (int c = 0; c < 50 && runs_seen < 2; c++) begin
            if (alu.run === 1'b1) runs_seen++;
            if (runs_seen < 2) @(negedge clk);
        end
        chk("t5 reached 2nd run", runs_seen, 2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t5 run", alu.run, 1'b0);
        chk("t5 busy", busy, 1'b0);
        chk("t5 cmd_out", alu.cmd_out, 12'h000);
        chk("t5 done", done, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 1'b0;
        seen_run  = 1'b0;
        for (int c = 0; c < 15; c++) begin
            if (done === 1'b1) seen_done = 1'b1;
            if (alu.run === 1'b1) seen_run = 1'b1;
            @(negedge clk);
        end
        chk("t5 no done", seen_done, 1'b0);
        chk("t5 no run", seen_run, 1'b0);
        run_prog("t5 rerun", 0);

        // start and ld_en while busy are dropped
        run_prog("t6", 4);
        run_prog("t6 rerun", 0);
        chk_res("t6 slot0", 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
